pam_tx_upsampler: RTL and testbench



---
 rtl/pam_tx_upsampler.sv | 96 +++++++++
 tb/tb_pam_tx_upsampler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_tx_upsampler.sv
// rtl/pam_tx_upsampler.sv - PAM-4 Gray mapper with 2-entry symbol FIFO and zero-stuffing upsampler
module pam_tx_upsampler #(
  parameter int OWIDTH = 14,
  parameter int SPS    = 8,
  parameter int AMP    = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               bits_in,
  input  logic                     bits_valid,
  output logic                     bits_ready,
  output logic signed [OWIDTH-1:0] out,
  output logic                     sym_strobe,
  output logic                     underrun
);

  localparam int PW = $clog2(SPS);
  localparam logic [PW-1:0] LAST = PW'(SPS - 1);
  localparam logic signed [OWIDTH-1:0] AMP1 = OWIDTH'(AMP);
  localparam logic signed [OWIDTH-1:0] AMP3 = OWIDTH'(3 * AMP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state, state_nxt;
  logic [PW-1:0]              phase, phase_nxt;
  logic [1:0]                 mem [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;
  logic                       slot, push, pop;
  logic signed [OWIDTH-1:0]   out_nxt;
  logic                       strobe_nxt, underrun_nxt;

  function automatic logic signed [OWIDTH-1:0] map_sym(input logic [1:0] s);
    case (s)
      2'b00:   map_sym = -AMP3;
      2'b01:   map_sym = -AMP1;
      2'b11:   map_sym = AMP1;
      default: map_sym = AMP3;
    endcase
  endfunction

  // Push is judged on the pre-pop count, so a full FIFO refuses even when a slot drains it.
  assign bits_ready = (count != 2'd2);
  assign push       = bits_valid && bits_ready;
  assign slot       = (phase == LAST);
  assign pop        = slot && (count != 2'd0);

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    out_nxt      = '0;
    strobe_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    if (slot) begin
      if (count != 2'd0) begin
        out_nxt    = map_sym(mem[rd_ptr]);
        strobe_nxt = 1'b1;
        phase_nxt  = '0;
        state_nxt  = RUN;
      end else begin
        underrun_nxt = (state == RUN);
        phase_nxt    = LAST;
        state_nxt    = IDLE;
      end
    end else begin
      phase_nxt = phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= LAST;
      out        <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      out        <= out_nxt;
      sym_strobe <= strobe_nxt;
      underrun   <= underrun_nxt;
      count      <= count + 2'(push) - 2'(pop);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bits_in;
  end

endmodule

// File: tb/tb_pam_tx_upsampler.sv
// tb/tb_pam_tx_upsampler.sv - bench for pam_tx_upsampler at SPS=8/AMP=2048 and SPS=2/AMP=2730
module tb_pam_tx_upsampler;

  localparam int OW = 14;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           bits_in [2];
  logic                 bits_valid [2];
  logic                 bits_ready [2];
  logic signed [OW-1:0] out_s [2];
  logic                 sym_strobe [2];
  logic                 underrun [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int S = (g == 0) ? 8 : 2;
    localparam int A = (g == 0) ? 2048 : 2730;

    pam_tx_upsampler #(.OWIDTH(OW), .SPS(S), .AMP(A)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bits_in(bits_in[g]),
      .bits_valid(bits_valid[g]),
      .bits_ready(bits_ready[g]),
      .out(out_s[g]),
      .sym_strobe(sym_strobe[g]),
      .underrun(underrun[g])
    );

    // Reference: slots are the first edge while idle, then every S edges after the last pop.
    int     q[$];
    int     exp_out = 0;
    bit     exp_stb = 1'b0;
    bit     exp_und = 1'b0;
    bit     running = 1'b0;
    longint cyc = 0;
    longint next_slot = 0;

    function automatic int amp_of(input int s);
      case (s)
        0:       return -3 * A;
        1:       return -A;
        3:       return A;
        default: return 3 * A;
      endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        exp_out = 0;
        exp_stb = 1'b0;
        exp_und = 1'b0;
        running = 1'b0;
        cyc     = 0;
      end else begin : step
        bit push_m;
        bit is_slot;
        push_m  = (bits_valid[g] === 1'b1) && (q.size() < 2);
        is_slot = !running || (cyc == next_slot);
        exp_out = 0;
        exp_stb = 1'b0;
        exp_und = 1'b0;
        if (is_slot) begin
          if (q.size() > 0) begin
            exp_out   = amp_of(q.pop_front());
            exp_stb   = 1'b1;
            running   = 1'b1;
            next_slot = cyc + S;
          end else if (running) begin
            exp_und = 1'b1;
            running = 1'b0;
          end
        end
        if (push_m) q.push_back(int'(bits_in[g]));
        cyc++;
      end
    end

    always @(negedge clk) begin
      check($sformatf("out_i%0d", g), out_s[g], exp_out);
      check($sformatf("strobe_i%0d", g), sym_strobe[g], exp_stb);
      check($sformatf("underrun_i%0d", g), underrun[g], exp_und);
      check($sformatf("ready_i%0d", g), bits_ready[g], (q.size() != 2));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input int i, input logic [1:0] s);
    int t = 0;
    bits_in[i]    = s;
    bits_valid[i] = 1'b1;
    while (!bits_ready[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 0, 1);
    @(negedge clk);
    bits_valid[i] = 1'b0;
  endtask

  task automatic wait_strobe(input int i);
    int t = 0;
    while (!sym_strobe[i] && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) check("strobe_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tbl [4];
    tbl = '{-6144, -2048, 2048, 6144};
    for (int i = 0; i < 2; i++) begin
      bits_in[i]    = 2'b00;
      bits_valid[i] = 1'b0;
    end

    // Reset held with valid asserted: nothing may enter the FIFO.
    bits_valid[0] = 1'b1;
    bits_in[0]    = 2'b10;
    idle(4);
    check("rst_out", out_s[0], 0);
    check("rst_strobe", sym_strobe[0], 0);
    check("rst_ready", bits_ready[0], 1);
    bits_valid[0] = 1'b0;
    rst_n = 1'b1;
    idle(3);
    check("rst_nopush", sym_strobe[0], 0);

    // Mapping: 00, 01, 11, 10 back-to-back.
    fork
      begin
        send(0, 2'b00);
        send(0, 2'b01);
        send(0, 2'b11);
        send(0, 2'b10);
      end
      begin
        wait_strobe(0);
        for (int idx = 0; idx <= 32; idx++) begin
          check("map_out", out_s[0], (idx < 32 && idx % 8 == 0) ? tbl[idx / 8] : 0);
          check("map_underrun", underrun[0], idx == 32);
          if (idx < 32) @(negedge clk);
        end
      end
    join
    idle(4);

    // Single symbol 10 from IDLE.
    send(0, 2'b10);
    check("single_lat0", out_s[0], 0);
    @(negedge clk);
    check("single_amp", out_s[0], 6144);
    check("single_strobe", sym_strobe[0], 1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check("single_zero", out_s[0], 0);
    end
    @(negedge clk);
    check("single_underrun", underrun[0], 1);
    idle(3);

    // Push coinciding with the empty slot in RUN.
    send(0, 2'b01);
    @(negedge clk);
    check("slot_first", out_s[0], -2048);
    idle(7);
    send(0, 2'b11);
    check("slot_underrun", underrun[0], 1);
    check("slot_underrun_out", out_s[0], 0);
    @(negedge clk);
    check("slot_strobe", sym_strobe[0], 1);
    check("slot_amp", out_s[0], 2048);
    idle(8);
    check("slot_cadence", underrun[0], 1);
    idle(3);

    // Backpressure: valid held continuously for 100 symbols.
    for (int n = 0; n < 100; n++) begin
      send(0, 2'($urandom_range(0, 3)));
      bits_valid[0] = 1'b1;
      if (n == 50) check("bp_ready_low", bits_ready[0], 0);
    end
    bits_valid[0] = 1'b0;
    idle(40);

    // Random symbols with random gaps, exercising underruns and slot-coincident pushes.
    for (int n = 0; n < 60; n++) begin
      send(0, 2'($urandom_range(0, 3)));
      idle($urandom_range(0, 20));
    end
    idle(30);

    // Asynchronous reset mid-symbol.
    send(0, 2'b00);
    bits_valid[0] = 1'b1;
    send(0, 2'b01);
    wait_strobe(0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out", out_s[0], 0);
    check("arst_strobe", sym_strobe[0], 0);
    check("arst_ready", bits_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    // Instance 1, SPS=2 AMP=2730: continuous stream of 10.
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          send(1, 2'b10);
          bits_valid[1] = 1'b1;
        end
        bits_valid[1] = 1'b0;
      end
      begin
        wait_strobe(1);
        for (int idx = 0; idx < 20; idx++) begin
          check("sps2_out", out_s[1], (idx % 2 == 0) ? 8190 : 0);
          check("sps2_strobe", sym_strobe[1], idx % 2 == 0);
          @(negedge clk);
        end
      end
    join
    idle(20);

    for (int n = 0; n < 80; n++) begin
      send(1, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) bits_valid[1] = 1'b1;
      else idle($urandom_range(0, 5));
    end
    bits_valid[1] = 1'b0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
